// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus slice seen by the MMIO UART transmitter.
// The core drives address, store data and the strobes, and the UART returns the load data.
interface mmio_uart_tx_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output mem_write, output mem_read, input rdata);
    modport slave  (input addr, input wdata, input mem_write, input mem_read, output rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a FIFO that is serialised LSB first.
// STATUS exposes the FIFO state, the busy flag and a sticky overflow flag.
module mmio_uart_tx #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0400
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_uart_tx_if.slave        bus,
    output logic                 tx,
    output logic                 busy
);
    localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            ovf_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [PW:0]     count_q;

    logic hit, full, empty, push, pop, bit_end;
    logic [31:0] status;

    assign hit     = (bus.addr[31:3] == BASE_ADDR[31:3]);
    assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    // Full is judged on the pre-edge count, so a pop on the same edge does not rescue the write.
    assign push    = hit & bus.mem_write & ~bus.addr[2] & ~full;
    assign bit_end = (timer_q == TW'(CLK_DIV - 1));
    assign busy    = (state_q != StIdle) | ~empty;
    assign tx      = tx_q;
    assign status  = {28'b0, ovf_q, busy, empty, full};

    assign bus.rdata = (hit && bus.mem_read && bus.addr[2]) ? status : 32'h0;

    logic unused;
    assign unused = ^{bus.wdata[31:8], bus.addr[1:0]};

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rptr_q];
                    timer_d = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = StData;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    timer_d = '0;
                    // Chain straight into the next start bit so queued bytes leave no idle gap.
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            if (hit && bus.mem_write && !bus.addr[2] && full) begin
                ovf_q <= 1'b1;
            end else if (hit && bus.mem_write && bus.addr[2] && bus.wdata[3]) begin
                ovf_q <= 1'b0;
            end
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            if (push && !pop) begin
                count_q <= count_q + (PW+1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= bus.wdata[7:0];
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus random bus traffic,
// compared every cycle against a frame-timing reference model.
module tb_mmio_uart_tx;
    localparam int unsigned CD    = 4;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0000_0400;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tx, busy;
    int   checks = 0;
    int   errors = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(
        .CLK_DIV    (CD),
        .FIFO_DEPTH (DEPTH),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Reference model: byte queue, current frame byte and edges elapsed since its start bit.
    logic [7:0] mq [$];
    bit         mact;
    int         fpos;
    logic [7:0] mcur;
    bit         movf;

    function automatic logic mhit(input logic [31:0] a);
        logic [31:0] b;
        b = BASE;
        return a[31:3] == b[31:3];
    endfunction

    function automatic logic [31:0] mstatus();
        logic [31:0] s;
        s = 32'h0;
        s[0] = (mq.size() == int'(DEPTH));
        s[1] = (mq.size() == 0);
        s[2] = mact || (mq.size() != 0);
        s[3] = movf;
        return s;
    endfunction

    function automatic logic mtx();
        int k;
        if (!mact) return 1'b1;
        k = fpos / int'(CD);
        if (k == 0) return 1'b0;
        if (k <= 8) return mcur[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        int pre;
        pre = mq.size();
        if (mact) fpos++;
        if (!mact || fpos == 10 * int'(CD)) begin
            if (mq.size() != 0) begin
                mcur = mq.pop_front();
                mact = 1'b1;
                fpos = 0;
            end else begin
                mact = 1'b0;
            end
        end
        if (w && mhit(a) && !a[2]) begin
            if (pre == int'(DEPTH)) movf = 1'b1;
            else mq.push_back(d[7:0]);
        end
        if (w && mhit(a) && a[2] && d[3]) movf = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] st;
        bus.mem_write = w;
        bus.mem_read  = r;
        bus.addr      = a;
        bus.wdata     = d;
        #3;
        check("rdata", bus.rdata, (r && mhit(a) && a[2]) ? mstatus() : 32'h0);
        @(posedge clk);
        model_edge(w, a, d);
        #1;
        st = mstatus();
        check("tx", {31'b0, tx}, {31'b0, mtx()});
        check("busy", {31'b0, busy}, {31'b0, st[2]});
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, BASE, 32'h0);
    endtask

    task automatic peek_status(input string tag, input logic [31:0] exp);
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b1;
        bus.addr      = BASE | 32'h4;
        bus.wdata     = 32'h0;
        #3;
        check(tag, bus.rdata, exp);
        step(1'b0, 1'b1, BASE | 32'h4, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("reset_tx", {31'b0, tx}, 32'h1);
        check("reset_busy", {31'b0, busy}, 32'h0);
        mq.delete();
        mact = 1'b0;
        fpos = 0;
        movf = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        int r;
        logic [31:0] a;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        bus.addr      = 32'h0;
        bus.wdata     = 32'h0;
        mact = 1'b0;
        fpos = 0;
        movf = 1'b0;
        #1;

        // Reset state
        do_reset();
        peek_status("status_after_reset", 32'h2);

        // Single frame 0x55
        step(1'b1, 1'b0, BASE, 32'h55);
        idle(45);
        peek_status("status_after_frame", 32'h2);

        // Burst of ten writes into a depth-8 FIFO
        for (int i = 1; i <= 10; i++) step(1'b1, 1'b0, BASE, i);
        peek_status("status_overflow", 32'hD);

        // Overflow clear semantics
        step(1'b1, 1'b0, BASE | 32'h4, 32'h0);
        peek_status("ovf_kept", 32'hD);
        step(1'b1, 1'b0, BASE | 32'h4, 32'h8);
        peek_status("ovf_cleared", 32'h5);
        idle(9 * 10 * CD + 20);
        peek_status("status_drained", 32'h2);

        // Non-hit accesses
        step(1'b1, 1'b0, 32'h0000_0408, $urandom);
        step(1'b0, 1'b1, 32'h0000_03FC, 32'h0);
        idle(10);
        peek_status("status_nonhit", 32'h2);

        // Reset during DATA bit 3 of 0xA5
        step(1'b1, 1'b0, BASE, 32'hA5);
        idle(18);
        do_reset();
        idle(60);
        peek_status("status_abort", 32'h2);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                step(1'b1, 1'b0, BASE | ($urandom & 32'h3), $urandom);
            end else if (r < 22) begin
                step(1'b0, 1'b1, BASE | 32'h4 | ($urandom & 32'h3), 32'h0);
            end else if (r < 27) begin
                step(1'b1, 1'b0, BASE | 32'h4, $urandom);
            end else if (r < 33) begin
                a = $urandom;
                step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a, $urandom);
            end else if (r < 37) begin
                step(1'b0, 1'b1, BASE, 32'h0);
            end else if (r == 37) begin
                do_reset();
            end else begin
                idle(1);
            end
        end
        idle(DEPTH * 10 * CD + 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
